adsr_envelope: RTL and testbench

Parametrised ADSR envelope generator on the 8 kHz envelope clock. It produces a VOL_W-bit volume for one voice channel and feeds the channel's amplitude scaler. This generation adds gate-driven (key-on/key-off) operation beside the timed mode, an explicit retrigger strobe in place of register-change detection, and loop/done strobes for the sweep and sequencer logic.

---
 rtl/adsr_envelope.sv | 168 ++++++++++++++++
 tb/tb_adsr_envelope.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// ADSR envelope generator for one voice channel, stepped on the 8 kHz envelope clock.
// Define ENV_EXP_RELEASE_EN for an exponential-style release (vol -= max(1, vol>>3)).
module adsr_envelope #(
    parameter int VOL_W  = 6,
    parameter int TIME_W = 8,
    parameter int LOOP_W = 4
) (
    input  logic              clk_8khz,
    input  logic              reset_n,
    input  logic              gate,
    input  logic              trig,
    input  logic              gate_mode,
    input  logic [TIME_W-1:0] atk_time,
    input  logic [TIME_W-1:0] dcy_time,
    input  logic [TIME_W-1:0] rel_time,
    input  logic [VOL_W-1:0]  sus_level,
    input  logic [TIME_W-1:0] sus_time,
    input  logic [1:0]        sus_shift,
    input  logic [LOOP_W-1:0] loop_cnt,
    output logic [VOL_W-1:0]  vol,
    output logic [2:0]        state,
    output logic              active,
    output logic              loop_stb,
    output logic              done_stb
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int TMR_W = TIME_W + 3;
    localparam logic [VOL_W-1:0] MAX = '1;

    state_t            st;
    logic [TMR_W-1:0]  timer;
    logic [LOOP_W-1:0] loops;
    logic              gate_q;
    logic              trigger;
    logic              gate_off;
    logic [TIME_W-1:0] stage_time;
    logic              step_due;
    logic [TMR_W-1:0]  sus_limit;

    function automatic logic [VOL_W-1:0] release_step(input logic [VOL_W-1:0] v);
        logic [VOL_W-1:0] dec;
`ifdef ENV_EXP_RELEASE_EN
        dec = v >> 3;
        if (dec == '0)
            dec = VOL_W'(1);
`else
        dec = VOL_W'(1);
`endif
        return (v > dec) ? (v - dec) : '0;
    endfunction

    assign state    = st;
    assign trigger  = trig | (gate & ~gate_q);
    assign gate_off = gate_mode & ~gate & (st == ATTACK || st == DECAY || st == SUSTAIN);
    // The widened shift keeps every bit of sus_time << 3.
    assign sus_limit = {3'b000, sus_time} << sus_shift;

    always_comb begin
        stage_time = rel_time;
        case (st)
            ATTACK:  stage_time = atk_time;
            DECAY:   stage_time = dcy_time;
            default: stage_time = rel_time;
        endcase
    end

    assign step_due = (timer >= {3'b000, stage_time});

    always_ff @(posedge clk_8khz) begin
        if (!reset_n) begin
            st       <= IDLE;
            vol      <= '0;
            timer    <= '0;
            loops    <= '0;
            gate_q   <= 1'b0;
            active   <= 1'b0;
            loop_stb <= 1'b0;
            done_stb <= 1'b0;
        end else begin
            gate_q   <= gate;
            loop_stb <= 1'b0;
            done_stb <= 1'b0;
            if (trigger) begin
                st     <= ATTACK;
                vol    <= '0;
                timer  <= '0;
                loops  <= loop_cnt;
                active <= 1'b1;
            end else if (gate_off) begin
                st    <= RELEASE;
                timer <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        vol   <= '0;
                        timer <= '0;
                    end
                    ATTACK: begin
                        if (!step_due) begin
                            timer <= timer + TMR_W'(1);
                        end else begin
                            timer <= '0;
                            if (vol == MAX)
                                st <= DECAY;
                            else
                                vol <= vol + VOL_W'(1);
                        end
                    end
                    DECAY: begin
                        if (!step_due) begin
                            timer <= timer + TMR_W'(1);
                        end else begin
                            timer <= '0;
                            if (vol <= sus_level)
                                st <= SUSTAIN;
                            else
                                vol <= vol - VOL_W'(1);
                        end
                    end
                    SUSTAIN: begin
                        // Gated sustain simply holds until the gate drops.
                        if (!gate_mode) begin
                            if (timer >= sus_limit) begin
                                timer <= '0;
                                st    <= RELEASE;
                            end else begin
                                timer <= timer + TMR_W'(1);
                            end
                        end
                    end
                    RELEASE: begin
                        if (!step_due) begin
                            timer <= timer + TMR_W'(1);
                        end else begin
                            timer <= '0;
                            if (vol != '0) begin
                                vol <= release_step(vol);
                            end else if (!gate_mode && loops != '0) begin
                                loops    <= loops - LOOP_W'(1);
                                st       <= ATTACK;
                                loop_stb <= 1'b1;
                            end else begin
                                st       <= IDLE;
                                active   <= 1'b0;
                                done_stb <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        st     <= IDLE;
                        vol    <= '0;
                        timer  <= '0;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: timed, gated, looped, retriggered and reset scenarios
// with hand-computed volume/state expectations.
module tb_adsr_envelope;

    logic       clk_8khz  = 1'b0;
    logic       reset_n   = 1'b0;
    logic       gate      = 1'b0;
    logic       trig      = 1'b0;
    logic       gate_mode = 1'b0;
    logic [7:0] atk_time  = '0;
    logic [7:0] dcy_time  = '0;
    logic [7:0] rel_time  = '0;
    logic [5:0] sus_level = '0;
    logic [7:0] sus_time  = '0;
    logic [1:0] sus_shift = '0;
    logic [3:0] loop_cnt  = '0;
    logic [5:0] vol;
    logic [2:0] state;
    logic       active;
    logic       loop_stb;
    logic       done_stb;

    int n_chk  = 0;
    int n_fail = 0;

    adsr_envelope #(.VOL_W(6), .TIME_W(8), .LOOP_W(4)) dut (
        .clk_8khz  (clk_8khz),
        .reset_n   (reset_n),
        .gate      (gate),
        .trig      (trig),
        .gate_mode (gate_mode),
        .atk_time  (atk_time),
        .dcy_time  (dcy_time),
        .rel_time  (rel_time),
        .sus_level (sus_level),
        .sus_time  (sus_time),
        .sus_shift (sus_shift),
        .loop_cnt  (loop_cnt),
        .vol       (vol),
        .state     (state),
        .active    (active),
        .loop_stb  (loop_stb),
        .done_stb  (done_stb)
    );

    always #5 clk_8khz = ~clk_8khz;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_8khz);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int phases;
        int lstb;
        int dstb;
        logic [2:0] prev;
        int seq[$];

        // Reset state
        tick(2);
        chk("rst_state", int'(state), 0);
        chk("rst_vol", int'(vol), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_loop_stb", int'(loop_stb), 0);
        chk("rst_done_stb", int'(done_stb), 0);
        reset_n = 1'b1;
        tick();
        chk("idle_after_rst", int'(state), 0);

        // Timed envelope: attack 0..63, decay to 32, 5-cycle sustain, release to 0
        sus_level = 6'd32;
        sus_time  = 8'd2;
        sus_shift = 2'd1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("t1_trig_state", int'(state), 1);
        chk("t1_trig_vol", int'(vol), 0);
        chk("t1_active", int'(active), 1);
        tick(63);
        chk("t1_atk_max_vol", int'(vol), 63);
        chk("t1_atk_max_state", int'(state), 1);
        tick();
        chk("t1_decay_state", int'(state), 2);
        chk("t1_decay_vol", int'(vol), 63);
        tick(31);
        chk("t1_decay_end_vol", int'(vol), 32);
        chk("t1_decay_end_state", int'(state), 2);
        tick();
        chk("t1_sus_state", int'(state), 3);
        chk("t1_sus_vol", int'(vol), 32);
        tick(4);
        chk("t1_sus_5th", int'(state), 3);
        tick();
        chk("t1_rel_state", int'(state), 4);
        chk("t1_rel_vol", int'(vol), 32);
        tick(32);
        chk("t1_rel_zero_vol", int'(vol), 0);
        chk("t1_rel_zero_state", int'(state), 4);
        chk("t1_no_early_done", int'(done_stb), 0);
        tick();
        chk("t1_idle_state", int'(state), 0);
        chk("t1_done_stb", int'(done_stb), 1);
        chk("t1_idle_active", int'(active), 0);
        tick();
        chk("t1_done_one_cycle", int'(done_stb), 0);

        // Gated: atk=1 steps every 2 cycles, gate drop at vol=20
        gate_mode = 1'b1;
        atk_time  = 8'd1;
        loop_cnt  = 4'd3;
        gate = 1'b1;
        tick();
        chk("t2_trig_state", int'(state), 1);
        chk("t2_trig_vol", int'(vol), 0);
        tick(39);
        chk("t2_vol19", int'(vol), 19);
        tick();
        chk("t2_vol20", int'(vol), 20);
        gate = 1'b0;
        tick();
        chk("t2_rel_state", int'(state), 4);
        chk("t2_rel_vol", int'(vol), 20);
        tick(20);
        chk("t2_rel_zero", int'(vol), 0);
        tick();
        chk("t2_idle_no_loop", int'(state), 0);
        chk("t2_done_stb", int'(done_stb), 1);
        chk("t2_loop_stb", int'(loop_stb), 0);

        // Trigger and gate fall in the same cycle: trigger wins
        gate = 1'b1;
        tick();
        tick(10);
        chk("t3_vol5", int'(vol), 5);
        gate = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("t3_trig_win_state", int'(state), 1);
        chk("t3_trig_win_vol", int'(vol), 0);
        tick();
        chk("t3_then_release", int'(state), 4);
        tick();
        chk("t3_idle", int'(state), 0);
        chk("t3_done", int'(done_stb), 1);

        // Timed looping, loop_cnt=2
        gate_mode = 1'b0;
        atk_time  = 8'd0;
        loop_cnt  = 4'd2;
        sus_level = 6'd60;
        sus_time  = 8'd0;
        sus_shift = 2'd0;
        phases = 0;
        lstb = 0;
        dstb = 0;
        prev = state;
        trig = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            trig = 1'b0;
            if (state == 3'd1 && prev != 3'd1) phases++;
            lstb += int'(loop_stb);
            dstb += int'(done_stb);
            prev = state;
            if (done_stb) break;
        end
        chk("t4_attack_phases", phases, 3);
        chk("t4_loop_stb_count", lstb, 2);
        chk("t4_done_stb_count", dstb, 1);
        tick();
        chk("t4_idle", int'(state), 0);
        chk("t4_done_cleared", int'(done_stb), 0);

        // Retrigger in SUSTAIN reloads loops
        loop_cnt  = 4'd0;
        sus_level = 6'd32;
        sus_time  = 8'd255;
        sus_shift = 2'd3;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick(96);
        chk("t5_sus_state", int'(state), 3);
        chk("t5_sus_vol", int'(vol), 32);
        loop_cnt = 4'd1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("t5_retrig_state", int'(state), 1);
        chk("t5_retrig_vol", int'(vol), 0);
        sus_time  = 8'd0;
        sus_shift = 2'd0;
        lstb = 0;
        dstb = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            lstb += int'(loop_stb);
            dstb += int'(done_stb);
            if (done_stb) break;
        end
        chk("t5_reloaded_loops", lstb, 1);
        chk("t5_done_count", dstb, 1);

        // Reset during DECAY, gate held high through reset
        loop_cnt = 4'd0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick(69);
        chk("t6_decay_state", int'(state), 2);
        chk("t6_decay_vol", int'(vol), 58);
        gate = 1'b1;
        reset_n = 1'b0;
        tick();
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_vol", int'(vol), 0);
        chk("t6_rst_active", int'(active), 0);
        chk("t6_rst_loop_stb", int'(loop_stb), 0);
        chk("t6_rst_done_stb", int'(done_stb), 0);
        tick();
        chk("t6_rst_gate_high", int'(state), 0);
        gate = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("t6_post_rst_idle", int'(state), 0);
        gate = 1'b1;
        tick();
        chk("t6_fresh_edge", int'(state), 1);

        // Release shape from full scale (gated, rel=0)
        gate_mode = 1'b1;
        gate = 1'b0;
        tick(3);
        chk("t7_idle", int'(state), 0);
        gate = 1'b1;
        tick();
        tick(63);
        chk("t7_full", int'(vol), 63);
        gate = 1'b0;
        tick();
        chk("t7_rel_state", int'(state), 4);
        chk("t7_rel_start", int'(vol), 63);
`ifdef ENV_EXP_RELEASE_EN
        seq = '{56, 49, 43, 38, 34, 30, 27, 24, 21, 19, 17, 15};
        for (int v = 14; v >= 0; v--) seq.push_back(v);
`else
        for (int v = 62; v >= 0; v--) seq.push_back(v);
`endif
        foreach (seq[i]) begin
            tick();
            chk("t7_rel_seq", int'(vol), seq[i]);
        end
        tick();
        chk("t7_idle_end", int'(state), 0);
        chk("t7_done", int'(done_stb), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
